dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, word-address width matching the data memory index (byte address bits [8:2]).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clk  input  1  CPU clock; the only clock; all state updates on rising edge.
REQ-004 rstn  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 req  input  2  per-port access request; port 0 is the CPU, port 1 is the debug/loader port; held high until gnt.
REQ-006 we  input  2  per-port write enable, qualified by req.
REQ-007 addr0, addr1  input  ADDR_W each  per-port word address.
REQ-008 wdata0, wdata1  input  DATA_W each  per-port write data.
REQ-009 gnt  output  2  one-cycle pulse: the port's access is on the memory bus this cycle.
REQ-010 rvalid  output  2  one-cycle pulse: rdata holds the port's read result.
REQ-011 rdata  output  DATA_W  registered read data, shared by both ports.
REQ-012 mem_we, mem_addr, mem_din  output  1 / ADDR_W / DATA_W  data-memory write enable, address and write data.
REQ-013 mem_dout  input  DATA_W  data-memory combinational read data.

Function
REQ-014 The FSM SHALL have two states: IDLE (no access latched) and ACC (an access is latched and driven to memory).
REQ-015 At each edge the arbiter SHALL pick one eligible requester and latch its id, we, addr and wdata into the access registers, entering ACC; with no eligible requester it SHALL enter IDLE.
REQ-016 A port is eligible when its req is high and it is not the port currently granted (gnt high this cycle); this prevents double service of a held req.
REQ-017 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred port; the preferred port wins a tie, and after each latch the pointer SHALL move to the other port.
REQ-018 A single eligible requester SHALL win regardless of the pointer.
REQ-019 In ACC: gnt[id]=1, mem_addr=latched addr, mem_din=latched wdata, mem_we=latched we; in IDLE: gnt=0, mem_we=0, and mem_addr/mem_din hold their last values.
REQ-020 For a read in ACC, rdata SHALL capture mem_dout at the closing edge and rvalid[id] SHALL pulse the following cycle; writes SHALL produce no rvalid.
REQ-021 Latency: req high in cycle 0 with no contention -> gnt in cycle 1 -> rvalid (reads) in cycle 2.
REQ-022 Throughput: one access per cycle when both ports request; a single port alone is served at most every other cycle.
REQ-023 rdata SHALL hold its value when rvalid is low.
REQ-024 Dropping req before gnt SHALL withdraw the request without side effect; changing addr/we/wdata while req is high and before gnt is permitted.

Reset
REQ-025 When rstn=0 at an edge: state=IDLE, pointer=0, gnt=0, rvalid=0, mem_we=0, rdata=0, mem_addr=0, mem_din=0.
REQ-026 Reset during ACC SHALL discard the latched access; no rvalid SHALL follow it, and mem_we SHALL be 0 from the cycle after the edge.
REQ-027 The first arbitration SHALL occur at the first edge with rstn=1.

Structure
REQ-028 A shared package dm_arb_pkg SHALL hold the state encoding (IDLE=0, ACC=1) and the ADDR_W/DATA_W defaults.
REQ-029 The two-way round-robin pick SHALL be a combinational sub-module dm_arb_rr (inputs: eligible[1:0], pointer; output: winner id, valid).
REQ-030 The block SHALL sit between the CPU data port and the single-port data memory in the top level, with port 1 driven by the loader.

Verification
REQ-031 Reset, then port 0 issues a read of addr 0x05 with mem[5]=0xDEADBEEF -> gnt=2'b01 in cycle 1, rvalid=2'b01 with rdata=0xDEADBEEF in cycle 2.
REQ-032 Both ports request in the same cycle after reset (pointer=0) -> gnt sequence 01,10,01,10 while both keep re-requesting.
REQ-033 Port 1 writes 0x12345678 to addr 0x7F, then port 0 reads 0x7F -> mem_we=1 in the write's gnt cycle only; the read returns 0x12345678.
REQ-034 Port 0 holds req continuously and alone -> gnt[0] pulses every other cycle, with no duplicate grant.
REQ-035 rstn=0 asserted during ACC of a port 1 read -> no rvalid, mem_we=0, gnt=0 after the edge; the next request after rstn=1 is served with pointer=0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dm_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dm_arb_rr.sv
// rtl/dm_arb_rr.sv - two-way round-robin pick among eligible requesters
module dm_arb_rr (
  input  logic [1:0] eligible_i,
  input  logic       pointer_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |eligible_i;
    winner_o = 1'b0;
    unique case (eligible_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = pointer_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port (CPU / loader) arbiter in front of a single-port data memory
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rvalid_q, rvalid_d;

  logic [1:0] eligible;
  logic       win_id;
  logic       win_valid;

  // The port on the bus this cycle is masked so a held req is not served twice.
  assign eligible = req & ~gnt;

  dm_arb_rr u_rr (
    .eligible_i (eligible),
    .pointer_i  (ptr_q),
    .winner_o   (win_id),
    .valid_o    (win_valid)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (win_valid) begin
      state_d = ST_ACC;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    mem_we = 1'b0;
    if (state_q == ST_ACC) begin
      gnt    = id_q ? 2'b10 : 2'b01;
      mem_we = we_q;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    if (win_valid) begin
      ptr_d   = ~ptr_q;
      id_d    = win_id;
      we_d    = win_id ? we[1] : we[0];
      addr_d  = win_id ? addr1 : addr0;
      wdata_d = win_id ? wdata1 : wdata0;
    end
    // Read data is taken at the edge that closes the access cycle.
    if (state_q == ST_ACC && !we_q) begin
      rdata_d  = mem_dout;
      rvalid_d = id_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter
module tb_dm_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    req, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sbq[$];

  logic [DW-1:0] shadow  [128];
  logic [DW-1:0] wmem    [128];
  logic [127:0]  written = '0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 7'h05) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | {25'd0, a};
  endfunction

  assign mem_dout = written[mem_addr] ? wmem[mem_addr] : init_word(mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      wmem[mem_addr]    <= mem_din;
      written[mem_addr] <= 1'b1;
    end
  end

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .we       (we),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  task automatic test_reset();
    rstn = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt !== 2'b00 || rvalid !== 2'b00 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b rvalid=%b mem_we=%b, required 00 00 0", gnt, rvalid, mem_we);
    end
    n_cmp++;
    if (rdata !== '0 || mem_addr !== '0 || mem_din !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_din=%h, required all zero", rdata, mem_addr, mem_din);
    end
    rstn = 1'b1;
  endtask

  task automatic test_single_read();
    exp_t e;
    req = 2'b01; we = 2'b00; addr0 = 7'h05;
    sbq.push_back('{port: 1'b0, data: shadow[5]});
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (rvalid !== 2'b00) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL single_rvalid: got rvalid=%b, required none", rvalid);
        end else begin
          e = sbq.pop_front();
          if (rvalid !== (e.port ? 2'b10 : 2'b01) || rdata !== e.data) begin
            n_fail++; $display("FAIL single_rdata: rvalid=%b rdata=%h, required port %0d data %h", rvalid, rdata, e.port, e.data);
          end
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (gnt !== 2'b01 || mem_addr !== 7'h05 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL single_gnt: gnt=%b addr=%h we=%b, required 01 05 0", gnt, mem_addr, mem_we);
        end
        req = 2'b00;
      end
      if (c == 2) begin
        n_cmp++;
        if (rvalid !== 2'b01) begin
          n_fail++; $display("FAIL single_latency: rvalid=%b in cycle 2, required 01", rvalid);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (rvalid !== 2'b00 || rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL single_hold: rvalid=%b rdata=%h, required 00 deadbeef", rvalid, rdata);
        end
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL single_drain: %0d reads outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_both();
    exp_t e;
    logic [1:0] exp_gnt [6];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    req = 2'b11; we = 2'b00; addr0 = 7'h01; addr1 = 7'h02;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back('{port: 1'b0, data: shadow[1]});
      sbq.push_back('{port: 1'b1, data: shadow[2]});
    end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (rvalid !== 2'b00) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL both_rvalid: got rvalid=%b, required none", rvalid);
        end else begin
          e = sbq.pop_front();
          if (rvalid !== (e.port ? 2'b10 : 2'b01) || rdata !== e.data) begin
            n_fail++; $display("FAIL both_rdata: rvalid=%b rdata=%h, required port %0d data %h", rvalid, rdata, e.port, e.data);
          end
        end
      end
      n_cmp++;
      if (gnt !== exp_gnt[c-1]) begin
        n_fail++; $display("FAIL both_gnt: cycle %0d gnt=%b, required %b", c, gnt, exp_gnt[c-1]);
      end
      if (c == 4) req = 2'b00;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL both_drain: %0d reads outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    req = 2'b10; we = 2'b10; addr1 = 7'h7F; wdata1 = 32'h12345678;
    shadow[127] = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (rvalid !== 2'b00) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL wr_rvalid: got rvalid=%b, required none", rvalid);
        end else begin
          e = sbq.pop_front();
          if (rvalid !== (e.port ? 2'b10 : 2'b01) || rdata !== e.data) begin
            n_fail++; $display("FAIL wr_rdata: rvalid=%b rdata=%h, required port %0d data %h", rvalid, rdata, e.port, e.data);
          end
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (gnt !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 7'h7F || mem_din !== 32'h12345678) begin
          n_fail++; $display("FAIL wr_write: gnt=%b we=%b addr=%h din=%h, required 10 1 7f 12345678", gnt, mem_we, mem_addr, mem_din);
        end
        req = 2'b01; we = 2'b00; addr0 = 7'h7F;
        sbq.push_back('{port: 1'b0, data: shadow[127]});
      end else begin
        n_cmp++;
        if (mem_we !== 1'b0) begin
          n_fail++; $display("FAIL wr_we_pulse: cycle %0d mem_we=%b, required 0", c, mem_we);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (gnt !== 2'b01) begin
          n_fail++; $display("FAIL wr_read_gnt: gnt=%b, required 01", gnt);
        end
        req = 2'b00;
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL wr_drain: %0d reads outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_hold_alone();
    exp_t e;
    req = 2'b01; we = 2'b00; addr0 = 7'h03;
    repeat (4) sbq.push_back('{port: 1'b0, data: shadow[3]});
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (rvalid !== 2'b00) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL hold_rvalid: got rvalid=%b, required none", rvalid);
        end else begin
          e = sbq.pop_front();
          if (rvalid !== (e.port ? 2'b10 : 2'b01) || rdata !== e.data) begin
            n_fail++; $display("FAIL hold_rdata: rvalid=%b rdata=%h, required port %0d data %h", rvalid, rdata, e.port, e.data);
          end
        end
      end
      if (c <= 8) begin
        n_cmp++;
        if (gnt !== ((c % 2 == 1) ? 2'b01 : 2'b00)) begin
          n_fail++; $display("FAIL hold_gnt: cycle %0d gnt=%b, required %b", c, gnt, (c % 2 == 1) ? 2'b01 : 2'b00);
        end
      end
      if (c == 8) req = 2'b00;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL hold_drain: %0d reads outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_acc();
    exp_t e;
    req = 2'b10; we = 2'b00; addr1 = 7'h09;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (rvalid !== 2'b00) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL rst_rvalid: got rvalid=%b, required none", rvalid);
        end else begin
          e = sbq.pop_front();
          if (rvalid !== (e.port ? 2'b10 : 2'b01) || rdata !== e.data) begin
            n_fail++; $display("FAIL rst_rdata: rvalid=%b rdata=%h, required port %0d data %h", rvalid, rdata, e.port, e.data);
          end
        end
      end
      case (c)
        1: begin
          n_cmp++;
          if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL rst_pre_gnt: gnt=%b, required 10", gnt);
          end
          rstn = 1'b0; req = 2'b00;
        end
        2: begin
          n_cmp++;
          if (gnt !== 2'b00 || rvalid !== 2'b00 || mem_we !== 1'b0 || rdata !== '0) begin
            n_fail++; $display("FAIL rst_discard: gnt=%b rvalid=%b we=%b rdata=%h, required 00 00 0 0", gnt, rvalid, mem_we, rdata);
          end
          rstn = 1'b1; req = 2'b11; addr0 = 7'h0A; addr1 = 7'h0B;
          sbq.push_back('{port: 1'b0, data: shadow[10]});
          sbq.push_back('{port: 1'b1, data: shadow[11]});
        end
        3: begin
          n_cmp++;
          if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL rst_ptr: gnt=%b, required 01", gnt);
          end
          req = 2'b10;
        end
        4: begin
          n_cmp++;
          if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL rst_second: gnt=%b, required 10", gnt);
          end
          req = 2'b00;
        end
        default: ;
      endcase
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL rst_drain: %0d reads outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) shadow[i] = init_word(i[AW-1:0]);
    test_reset();
    test_single_read();
    test_both();
    test_write_read();
    test_hold_alone();
    test_reset_acc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
